// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the ALU class and all enables.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [1:0] aluOP,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WR    = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   opcode_legal;

    // Moore control word for a state; anything not listed stays 0.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE:    c.alu_src_b = 2'b11;
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEM_WR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
            end
            R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b11;
            end
            ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        opcode_legal = 1'b1;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
            default:                                       opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EXEC;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:    state_d = MEM_WB;
            R_EXEC:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase
        ctrl_d = decode_ctrl(state_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // The control word is registered alongside the state, so reset clears it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign illegal_op = (state_q == DECODE) && !opcode_legal;
    assign instr_done = ctrl_q.instr_done | illegal_op;
    assign pc_en      = ctrl_q.pc_write | (ctrl_q.pc_write_cond & zero);
    assign aluOP      = ctrl_q.alu_op;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign pc_source  = ctrl_q.pc_source;
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign state      = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle datapath; the producer side of the ALU interface.
- Sequences fetch, decode, execute, memory and writeback, one state per cycle.
- Drives ALU operation class `aluOP` and all datapath enables.
- Consumes the ALU `zero` flag to resolve branches. The ALU itself decodes funct when `aluOP`=10.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- aluOP  out  2  00 add, 01 subtract, 10 funct-decoded, 11 add-immediate
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  pc_write | (pc_write_cond & zero)
- i_or_d  out  1  memory address select, 0=PC, 1=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write
- instr_done  out  1  1-cycle pulse in an instruction's last state
- illegal_op  out  1  1-cycle pulse: unsupported opcode seen in DECODE
- state  out  4  current state encoding, for debug

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6
  - R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12
- Reset:
  - `rst` high asynchronously forces state=IDLE.
  - In IDLE every output is 0, including `aluOP`=00 and `state`=0.
  - IDLE -> FETCH unconditionally on the first clock after `rst` falls.
  - Reset asserted mid-instruction aborts it immediately; no partial write is issued after reset.
- Outputs are Moore (decoded from the registered state only). Exceptions: `pc_en` also uses `zero`; `illegal_op` also uses `opcode`. Unlisted outputs are 0.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, aluOP=00, pc_source=00, pc_write=1 (so PC<=PC+4). Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, aluOP=00 (branch target precompute). Next by opcode:
    - LW/SW -> MEM_ADDR; RTYPE -> R_EXEC; BEQ -> BRANCH; J -> JUMP; ADDI -> ADDI_EXEC
    - any other opcode -> FETCH, with illegal_op=1 and instr_done=1
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, aluOP=00. Next: MEM_RD if LW, MEM_WR if SW. Opcode is stable; IR is not written outside FETCH.
  - MEM_RD: mem_read=1, i_or_d=1 -> MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
  - MEM_WR: mem_write=1, i_or_d=1, instr_done=1 -> FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, aluOP=10 -> R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, aluOP=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH. `pc_en`=`zero` combinationally in this state.
  - JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, aluOP=11 -> ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- Latency in cycles, FETCH through last state: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- `zero` is ignored in every state except BRANCH. `pc_en` is 0 in every state except FETCH, JUMP and BRANCH.
- `mem_read` and `mem_write` are never high in the same cycle. `reg_write` and `mem_write` are never high in the same cycle.
- Unused state encodings 13-15 go to FETCH on the next clock with all outputs 0.

Test Plan:
- Reset, then release `rst`: state 0 for one cycle, then 1. All outputs 0 in IDLE. In FETCH: mem_read=1, ir_write=1, pc_en=1, aluOP=00, alu_src_b=01.
- opcode=100011 (LW): state sequence 1,2,3,4,5,1. reg_write=1 and mem_to_reg=1 only in state 5. instr_done pulses exactly once.
- opcode=000000 (R-type): aluOP=10 in state 7; reg_dst=1, reg_write=1 in state 8. opcode=001000 (ADDI): aluOP=11 in state 11.
- opcode=000100 (BEQ), zero=1 in BRANCH: pc_en=1, pc_source=01, aluOP=01. Repeat with zero=0: pc_en=0. In both cases the next state is FETCH.
- opcode=111111: DECODE asserts illegal_op=1 and instr_done=1, returns to FETCH; no mem_write or reg_write at any point.
- Assert `rst` mid-clock while in MEM_WR with mem_write=1: mem_write drops to 0 without waiting for a clock edge, and state=0. After release, execution restarts at FETCH.
